uart_cmd_controller: RTL and testbench

UART_CMD_CONTROLLER -- requirements
Module: uart_cmd_controller

---
 rtl/uart_cmd_controller.sv | 195 +++++++++++++++++++
 tb/tb_uart_cmd_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_controller
// Purpose  : Byte-command front end that sits between a UART and a
//            computation core. Received bytes carry a 4-bit opcode (low
//            nibble) and a 4-bit payload (high nibble). LOAD shifts the
//            payload into operand register X, COMPUTE starts the core,
//            STATUS reports the sticky flags and CLEAR resets X and the
//            flags. Each command produces one reply byte.
// Ports    : clk       - single clock, posedge
//            rst_n     - asynchronous active-low reset
//            rx_valid  - one-cycle strobe for a received byte
//            rx_byte   - received byte {payload, opcode}
//            tx_ready  - transmitter accepts a byte this cycle
//            tx_valid  - reply byte available
//            tx_byte   - reply byte
//            core_ld   - core hold (1) / compute (0)
//            core_x    - operand register X
//            core_dn   - core result valid
//            core_y    - core result
// Config   : CTRL_WATCHDOG_EN - when defined, a compute that runs for
//            WDOG_CYCLES cycles without core_dn is abandoned with a
//            timeout reply and the sticky tmo flag is set.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_controller #(
    parameter int W           = 368,
    parameter int WDOG_CYCLES = 16777216
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         tx_ready,
    output logic         tx_valid,
    output logic [7:0]   tx_byte,
    output logic         core_ld,
    output logic [W-1:0] core_x,
    input  logic         core_dn,
    input  logic [W-1:0] core_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [3:0] c_op_load    = 4'h0;
    localparam logic [3:0] c_op_compute = 4'h2;
    localparam logic [3:0] c_op_status  = 4'h4;
    localparam logic [3:0] c_op_clear   = 4'h6;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_x;
    logic [W-1:0]   w_x_nxt;
    logic           r_ovr;
    logic           w_ovr_nxt;
    logic [7:0]     r_tx_byte;
    logic [7:0]     w_tx_byte_nxt;
    logic           r_core_ld;
    logic           w_tmo;

`ifdef CTRL_WATCHDOG_EN
    localparam int              c_wdog_w    = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(WDOG_CYCLES - 1);

    logic                r_tmo;
    logic                w_tmo_nxt;
    logic [c_wdog_w-1:0] r_wdog;
    logic [c_wdog_w-1:0] w_wdog_nxt;

    assign w_tmo = r_tmo;
`else
    assign w_tmo = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_ovr     <= 1'b0;
            r_tx_byte <= 8'h00;
            r_core_ld <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_ovr     <= w_ovr_nxt;
            r_tx_byte <= w_tx_byte_nxt;
            // The core computes exactly while the controller sits in RUN.
            r_core_ld <= (w_state_nxt != RUN);
        end
    end

`ifdef CTRL_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo  <= 1'b0;
            r_wdog <= '0;
        end else begin
            r_tmo  <= w_tmo_nxt;
            r_wdog <= w_wdog_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_ovr_nxt     = r_ovr;
        w_tx_byte_nxt = r_tx_byte;
`ifdef CTRL_WATCHDOG_EN
        w_tmo_nxt     = r_tmo;
        w_wdog_nxt    = r_wdog;
`endif
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    w_state_nxt = SEND;
                    case (rx_byte[3:0])
                        c_op_load: begin
                            // First nibble sent ends up at X[3:0] after W/4 loads.
                            w_x_nxt       = {rx_byte[7:4], r_x[W-1:4]};
                            w_tx_byte_nxt = {r_x[3:0], 4'h1};
                        end
                        c_op_compute: begin
                            w_state_nxt = RUN;
`ifdef CTRL_WATCHDOG_EN
                            w_wdog_nxt  = '0;
`endif
                        end
                        c_op_status: begin
                            w_tx_byte_nxt = {r_ovr, w_tmo, 2'b00, 4'h5};
                        end
                        c_op_clear: begin
                            w_x_nxt       = '0;
                            w_ovr_nxt     = 1'b0;
`ifdef CTRL_WATCHDOG_EN
                            w_tmo_nxt     = 1'b0;
`endif
                            w_tx_byte_nxt = 8'h07;
                        end
                        default: begin
                            w_tx_byte_nxt = 8'h0F;
                        end
                    endcase
                end
            end
            RUN: begin
                if (rx_valid) begin
                    w_ovr_nxt = 1'b1;
                end
                // A result arriving on the watchdog's last cycle still wins.
                if (core_dn) begin
                    w_x_nxt       = core_y;
                    w_tx_byte_nxt = 8'h03;
                    w_state_nxt   = SEND;
`ifdef CTRL_WATCHDOG_EN
                end else if (r_wdog == c_wdog_last) begin
                    w_tmo_nxt     = 1'b1;
                    w_tx_byte_nxt = 8'h0E;
                    w_state_nxt   = SEND;
                end else begin
                    w_wdog_nxt    = r_wdog + 1'b1;
`endif
                end
            end
            SEND: begin
                if (rx_valid) begin
                    w_ovr_nxt = 1'b1;
                end
                if (tx_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign tx_valid = (r_state == SEND);
    assign tx_byte  = r_tx_byte;
    assign core_ld  = r_core_ld;
    assign core_x   = r_x;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_controller
// Purpose  : Directed self-checking bench for uart_cmd_controller (W=8,
//            WDOG_CYCLES=4). Covers reset, LOAD, COMPUTE, backpressure with
//            overrun, other opcodes, CLEAR, reset mid-RUN and the watchdog
//            (or its absence when CTRL_WATCHDOG_EN is undefined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_controller;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         tx_ready;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic         core_ld;
    logic [W-1:0] core_x;
    logic         core_dn;
    logic [W-1:0] core_y;

    int vectors     = 0;
    int miscompares = 0;

    uart_cmd_controller #(
        .W           (W),
        .WDOG_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_byte  (tx_byte),
        .core_ld  (core_ld),
        .core_x   (core_x),
        .core_dn  (core_dn),
        .core_y   (core_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    // Wait (bounded) for a reply, check it, and let it transfer.
    task automatic get_reply(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(tx_valid), 64'd1);
        check(tag, 64'(tx_byte), 64'(exp));
        tx_ready = 1'b1;
        tick();
        check({tag, "_done"}, 64'(tx_valid), 64'd0);
    endtask

    initial begin
        int low_cnt;
        int n;
        int seen_tx;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_ready = 1'b1;
        core_dn  = 1'b0;
        core_y   = '0;

        // Reset state
        tick();
        tick();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_byte",  64'(tx_byte),  64'd0);
        check("rst_core_ld",  64'(core_ld),  64'd1);
        check("rst_core_x",   64'(core_x),   64'd0);
        rst_n = 1'b1;
        tick();

        // LOAD: 0x10 then 0x20 -> X = 0x21
        send_byte(8'h10);
        get_reply("load1", 8'h01);
        check("load1_x", 64'(core_x), 64'h10);
        send_byte(8'h20);
        get_reply("load2", 8'h01);
        check("load2_x", 64'(core_x), 64'h21);

        // COMPUTE: core_dn ten cycles after the command
        core_y = 8'hA5;
        send_byte(8'h02);
        low_cnt = (core_ld == 1'b0) ? 1 : 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (core_ld == 1'b0) low_cnt++;
        end
        check("run_x_hold", 64'(core_x), 64'h21);
        check("run_no_tx",  64'(tx_valid), 64'd0);
        core_dn = 1'b1;
        tick();
        core_dn = 1'b0;
        check("comp_ld_low_cycles", 64'(low_cnt), 64'd10);
        check("comp_ld_back", 64'(core_ld), 64'd1);
        check("comp_x", 64'(core_x), 64'hA5);
        get_reply("comp", 8'h03);

        // Backpressure + overrun during SEND
        tx_ready = 1'b0;
        send_byte(8'h04);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                rx_valid = 1'b1;
                rx_byte  = 8'h04;
            end
            tick();
            rx_valid = 1'b0;
            check("bp_valid", 64'(tx_valid), 64'd1);
            check("bp_byte",  64'(tx_byte),  64'h05);
        end
        tx_ready = 1'b1;
        tick();
        check("bp_done", 64'(tx_valid), 64'd0);
        check("ovr_x_hold", 64'(core_x), 64'hA5);
        send_byte(8'h04);
        get_reply("status_ovr", 8'h85);

        // Other opcode and CLEAR
        send_byte(8'h09);
        get_reply("illegal", 8'h0F);
        check("illegal_x", 64'(core_x), 64'hA5);
        send_byte(8'h06);
        get_reply("clear", 8'h07);
        check("clear_x", 64'(core_x), 64'h00);
        send_byte(8'h04);
        get_reply("status_clr", 8'h05);

        // Reset mid-RUN
        send_byte(8'h50);
        get_reply("load3", 8'h01);
        check("load3_x", 64'(core_x), 64'h50);
        send_byte(8'h02);
        tick();
        check("rr_ld_low", 64'(core_ld), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rr_ld", 64'(core_ld), 64'd1);
        check("rr_x",  64'(core_x),  64'h00);
        tick();
        rst_n   = 1'b1;
        seen_tx = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tx_valid) seen_tx++;
        end
        check("rr_no_tx", 64'(seen_tx), 64'd0);
        check("rr_idle_ld", 64'(core_ld), 64'd1);

`ifdef CTRL_WATCHDOG_EN
        // Watchdog: 4 RUN cycles, then timeout reply
        send_byte(8'h02);
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        check("wdog_cycles", 64'(n), 64'd4);
        check("wdog_ld", 64'(core_ld), 64'd1);
        check("wdog_x", 64'(core_x), 64'h00);
        get_reply("wdog", 8'h0E);
        send_byte(8'h04);
        get_reply("status_tmo", 8'h45);
`else
        // No watchdog: RUN waits until the core finishes
        send_byte(8'h02);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_valid || core_ld) n++;
        end
        check("nowdog_wait", 64'(n), 64'd0);
        core_y  = 8'h3C;
        core_dn = 1'b1;
        tick();
        core_dn = 1'b0;
        check("nowdog_x", 64'(core_x), 64'h3C);
        get_reply("nowdog", 8'h03);
        send_byte(8'h04);
        get_reply("status_notmo", 8'h05);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
